audio_sample_serializer: RTL and testbench

- Sits between the DSP stereo output (dac_out_l/dac_out_r) and the SSM2603 DAC pins (AUD_DACDAT/AUD_DACLRCK).
- Buffers stereo sample pairs in a small FIFO.
- Serialises each pair as a 64-BCLK I2S frame: two 32-bit slots, 16-bit two's-complement MSB-first, 1-bit delay after each LRCK edge.
- Clocked by the audio bit clock (2.048 MHz, 32 kHz frame rate); counts underruns for debug LEDs/UART readback.

---
 rtl/audio_pkg.sv | 10 +
 rtl/sample_pair_fifo.sv | 38 +++
 rtl/audio_sample_serializer.sv | 77 +++++++
 tb/tb_audio_sample_serializer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared audio widths, stereo pair type and underrun saturation limit
package audio_pkg;
  localparam int AUDIO_SAMPLE_WIDTH = 16;
  localparam int AUDIO_SLOT_WIDTH = 32;
  localparam logic [7:0] UNDERRUN_MAX = 8'd255;
  typedef struct packed {
    logic [AUDIO_SAMPLE_WIDTH-1:0] l;
    logic [AUDIO_SAMPLE_WIDTH-1:0] r;
  } stereo_pair_t;
endpackage

// File: rtl/sample_pair_fifo.sv
// sample_pair_fifo: sync FIFO of packed stereo pairs; ports clock, reset, push, pop, wdata -> rdata (head), level, full, empty
module sample_pair_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rd];
  always_ff @(posedge clock)
    if (do_push) mem[wr] <= wdata;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr <= '0;
      rd <= '0;
      level <= '0;
    end else begin
      wr <= do_push ? wr + 1'b1 : wr;
      rd <= do_pop ? rd + 1'b1 : rd;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/audio_sample_serializer.sv
// audio_sample_serializer: FIFO-buffered stereo I2S serializer (clock, reset, in_sample_l/r, in_valid -> out_ready, dac_data, dac_lrclk, frame_start, fifo_level, underrun_count); AUDIO_SER_HOLD_LAST_EN repeats the last pair on underrun
module audio_sample_serializer
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH = AUDIO_SLOT_WIDTH,
  parameter int FIFO_DEPTH = 4,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] in_sample_l,
  input  logic [SAMPLE_WIDTH-1:0] in_sample_r,
  input  logic                    in_valid,
  output logic                    out_ready,
  output logic                    dac_data,
  output logic                    dac_lrclk,
  output logic                    frame_start,
  output logic [LW-1:0]           fifo_level,
  output logic [7:0]              underrun_count
);
  localparam int FRAME = 2 * SLOT_WIDTH;
  localparam int NW = $clog2(FRAME);
  localparam int PW = 2 * SAMPLE_WIDTH;
  logic [NW-1:0] n, n_nx, k_nx;
  logic last, lr_nx, in_bits, full, empty;
  logic [SAMPLE_WIDTH-1:0] sh_l, sh_r, ld_l, ld_r, fb_l, fb_r;
  logic [PW-1:0] head;
  assign last = n == NW'(FRAME - 1);
  assign n_nx = last ? '0 : n + 1'b1;
  assign lr_nx = n_nx >= NW'(SLOT_WIDTH);
  assign k_nx = lr_nx ? n_nx - NW'(SLOT_WIDTH) : n_nx;
  assign in_bits = k_nx != '0 && k_nx <= NW'(SAMPLE_WIDTH);
  assign out_ready = !full;
  assign {ld_l, ld_r} = empty ? {fb_l, fb_r} : head;
  sample_pair_fifo #(.W(PW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(in_valid && !full),
    .pop(last && !empty),
    .wdata({in_sample_l, in_sample_r}),
    .rdata(head),
    .level(fifo_level),
    .full(full),
    .empty(empty)
  );
`ifdef AUDIO_SER_HOLD_LAST_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) {fb_l, fb_r} <= '0;
    else if (last && !empty) {fb_l, fb_r} <= head;
`else
  assign fb_l = '0;
  assign fb_r = '0;
`endif
  // outputs are registered from the next count so each cycle shows the bit for its own n
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      n <= '0;
      sh_l <= '0;
      sh_r <= '0;
      dac_data <= 1'b0;
      dac_lrclk <= 1'b0;
      frame_start <= 1'b0;
      underrun_count <= '0;
    end else begin
      n <= n_nx;
      dac_lrclk <= lr_nx;
      frame_start <= n_nx == NW'(FRAME - 1);
      dac_data <= in_bits && (lr_nx ? sh_r[SAMPLE_WIDTH-1] : sh_l[SAMPLE_WIDTH-1]);
      if (last) begin
        sh_l <= ld_l;
        sh_r <= ld_r;
        underrun_count <= empty && underrun_count != UNDERRUN_MAX ? underrun_count + 1'b1 : underrun_count;
      end else if (in_bits && lr_nx) sh_r <= sh_r << 1;
      else if (in_bits) sh_l <= sh_l << 1;
    end
endmodule

// File: tb/tb_audio_sample_serializer.sv
// tb_audio_sample_serializer: queue-based reference model with per-cycle compare plus directed literal checks
module tb_audio_sample_serializer;
  import audio_pkg::*;
`ifdef AUDIO_SER_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  logic clock = 0, reset = 0, in_valid = 0;
  logic [15:0] in_sample_l = '0, in_sample_r = '0;
  logic out_ready, dac_data, dac_lrclk, frame_start;
  logic [2:0] fifo_level;
  logic [7:0] underrun_count;
  int total = 0, bad = 0;
  bit checking = 0;
  stereo_pair_t mq[$];
  stereo_pair_t m_pair = '0, m_last = '0;
  int m_n = 0, m_under = 0;
  bit m_acc;

  always #5 clock = ~clock;

  audio_sample_serializer dut (
    .clock(clock), .reset(reset), .in_sample_l(in_sample_l), .in_sample_r(in_sample_r),
    .in_valid(in_valid), .out_ready(out_ready), .dac_data(dac_data), .dac_lrclk(dac_lrclk),
    .frame_start(frame_start), .fifo_level(fifo_level), .underrun_count(underrun_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic exp_bit();
    logic [15:0] s;
    int k;
    s = m_n >= 32 ? m_pair.r : m_pair.l;
    k = m_n % 32;
    return (k >= 1 && k <= 16) ? s[16-k] : 1'b0;
  endfunction

  function automatic logic [15:0] left_word(input logic [63:0] d);
    logic [15:0] w;
    for (int i = 1; i <= 16; i++) w[16-i] = d[i];
    return w;
  endfunction

  function automatic logic [15:0] right_word(input logic [63:0] d);
    logic [15:0] w;
    for (int i = 1; i <= 16; i++) w[16-i] = d[32+i];
    return w;
  endfunction

  // reference model: FIFO as a queue, frame position as a plain integer
  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      mq.delete();
      m_pair = '0;
      m_last = '0;
      m_n = 0;
      m_under = 0;
    end else begin
      m_acc = in_valid && mq.size() < 4;
      if (m_n == 63) begin
        if (mq.size() > 0) begin
          m_pair = mq.pop_front();
          m_last = m_pair;
        end else begin
          m_pair = HOLD ? m_last : '0;
          if (m_under < 255) m_under++;
        end
      end
      if (m_acc) mq.push_back({in_sample_l, in_sample_r});
      m_n = (m_n + 1) % 64;
    end
  end

  initial forever begin
    @(negedge clock);
    if (checking) begin
      chk("dac_data", dac_data, exp_bit());
      chk("dac_lrclk", dac_lrclk, m_n >= 32);
      chk("frame_start", frame_start, m_n == 63);
      chk("fifo_level", fifo_level, mq.size());
      chk("out_ready", out_ready, mq.size() < 4);
      chk("underrun", underrun_count, m_under);
    end
  end

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1;
    repeat (3) @(negedge clock);
    reset = 0;
  endtask

  task automatic wait_fs();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (frame_start) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL frame_start_timeout t=%0t", $time);
    end
  endtask

  task automatic cap(output logic [63:0] d, output logic [63:0] lr);
    for (int j = 0; j < 64; j++) begin
      @(negedge clock);
      d[j] = dac_data;
      lr[j] = dac_lrclk;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] d, lr;
    logic [15:0] l4;
    int u0, fs_cnt, last_fs, first_fs, gap_bad, data_nz, acc, fs_at, acc_at, cnt;
    bit acc_now;
    #3 reset = 1;
    @(negedge clock);
    checking = 1;
    chk("rst_data", dac_data, 0);
    chk("rst_ready", out_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_underrun", underrun_count, 0);
    repeat (2) @(negedge clock);
    reset = 0;
    // first pair pushed before the first pop, plays in frame 1
    in_sample_l = 16'h8001;
    in_sample_r = 16'h7FFE;
    in_valid = 1;
    @(negedge clock);
    in_valid = 0;
    wait_fs();
    cap(d, lr);
    chk("t1_left", left_word(d), 16'h8001);
    chk("t1_right", right_word(d), 16'h7FFE);
    chk("t1_lrclk", lr, 64'hFFFFFFFF_00000000);
    chk("t1_zero_bits", d & 64'hFFFE0001_FFFE0001, 0);
    // three starved frames
    do_reset();
    fs_cnt = 0; last_fs = -1; first_fs = -1; gap_bad = 0; data_nz = 0;
    for (int j = 1; j <= 192; j++) begin
      @(negedge clock);
      if (dac_data) data_nz++;
      if (frame_start) begin
        if (last_fs >= 0 && j - last_fs != 64) gap_bad++;
        if (first_fs < 0) first_fs = j;
        last_fs = j;
        fs_cnt++;
      end
    end
    chk("t2_underrun", underrun_count, 3);
    chk("t2_fs_count", fs_cnt, 3);
    chk("t2_fs_gap", gap_bad, 0);
    chk("t2_first_fs", first_fs, 63);
    chk("t2_silent", data_nz, 0);
    // five back-to-back pushes into a depth-4 FIFO
    acc = 0; fs_at = -1; acc_at = -1;
    in_sample_l = 16'($urandom);
    in_sample_r = 16'($urandom);
    in_valid = 1;
    for (int j = 0; j < 200; j++) begin
      acc_now = out_ready;
      if (frame_start) fs_at = j;
      if (acc_now) begin
        acc++;
        if (acc == 5) acc_at = j;
      end
      @(negedge clock);
      if (acc_now) begin
        in_sample_l = 16'($urandom);
        in_sample_r = 16'($urandom);
      end
      if (acc == 4 && acc_now) begin
        chk("t3_ready_drop", out_ready, 0);
        chk("t3_level4", fifo_level, 4);
      end
      if (acc == 5) break;
    end
    in_valid = 0;
    chk("t3_accepted", acc, 5);
    chk("t3_fifth_after_pop", acc_at - fs_at, 1);
    repeat (6 * 64) @(negedge clock);
    // push in the pop cycle with the FIFO empty
    wait_fs();
    chk("t4_empty", fifo_level, 0);
    u0 = underrun_count;
    l4 = 16'($urandom);
    in_sample_l = l4;
    in_sample_r = 16'($urandom);
    in_valid = 1;
    @(negedge clock);
    in_valid = 0;
    chk("t4_underrun_inc", underrun_count, u0 + 1);
    chk("t4_level", fifo_level, 1);
    wait_fs();
    cap(d, lr);
    chk("t4_left", left_word(d), l4);
    // reset mid-frame with two pairs buffered
    wait_fs();
    in_valid = 1;
    in_sample_l = 16'($urandom);
    @(negedge clock);
    in_sample_l = 16'($urandom);
    @(negedge clock);
    in_valid = 0;
    for (int j = 0; j < 100 && m_n != 40; j++) @(negedge clock);
    chk("t5_at_n40", m_n, 40);
    chk("t5_level2", fifo_level, 2);
    #2 reset = 1;
    #1;
    chk("t5_rst_data", dac_data, 0);
    chk("t5_rst_lrclk", dac_lrclk, 0);
    chk("t5_rst_fs", frame_start, 0);
    chk("t5_rst_level", fifo_level, 0);
    chk("t5_rst_underrun", underrun_count, 0);
    repeat (2) @(negedge clock);
    reset = 0;
    cnt = 0;
    for (int j = 1; j <= 200; j++) begin
      @(negedge clock);
      if (frame_start) begin
        cnt = j;
        break;
      end
    end
    chk("t5_restart", cnt, 63);
    @(negedge clock);
    chk("t5_first_underrun", underrun_count, 1);
    // random traffic
    for (int j = 0; j < 12 * 64; j++) begin
      in_valid = $urandom_range(0, 40) == 0;
      in_sample_l = 16'($urandom);
      in_sample_r = 16'($urandom);
      @(negedge clock);
    end
    in_valid = 0;
    // starve after one played pair
    do_reset();
    in_sample_l = 16'h1234;
    in_sample_r = 16'($urandom);
    in_valid = 1;
    @(negedge clock);
    in_valid = 0;
    wait_fs();
    wait_fs();
    cap(d, lr);
    chk("t7_left", left_word(d), HOLD ? 16'h1234 : 16'h0000);
    chk("t7_underrun", underrun_count, 1);
    // saturation
    do_reset();
    repeat (258 * 64) @(negedge clock);
    chk("t8_saturate", underrun_count, 255);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
